// File: rtl/serv_alu_digit_seq.sv
// Operand sequencer / result collector for the digit-serial ALU: streams one
// parallel operation through the ALU W bits per cycle and reassembles the result.
module serv_alu_digit_seq #(
    parameter int W    = 8,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_sub,
    input  logic [1:0]      i_bool_op,
    input  logic            i_cmp_eq,
    input  logic            i_cmp_sig,
    input  logic [2:0]      i_rd_sel,
    output logic            o_alu_en,
    output logic            o_alu_cnt0,
    output logic            o_alu_sub,
    output logic [1:0]      o_alu_bool_op,
    output logic            o_alu_cmp_eq,
    output logic            o_alu_cmp_sig,
    output logic [2:0]      o_alu_rd_sel,
    output logic [W-1:0]    o_alu_rs1,
    output logic [W-1:0]    o_alu_op_b,
    output logic [W-1:0]    o_alu_buf,
    input  logic [W-1:0]    i_alu_rd,
    input  logic            i_alu_cmp,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_cmp
);
    localparam int N  = XLEN / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] op_b_reg;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] result_next;
    logic [CW-1:0]   cnt_reg;
    logic            sub_reg;
    logic [1:0]      bool_op_reg;
    logic            cmp_eq_reg;
    logic            cmp_sig_reg;
    logic [2:0]      rd_sel_reg;
    logic            ready_reg;
    logic            valid_reg;
    logic            en_reg;
    logic            cnt0_reg;
    logic            cmp_reg;

    // New digits enter at the top so the first (LSB) digit ends up at bit 0.
    generate
        if (N > 1) begin : g_multi
            assign result_next = {i_alu_rd, result_reg[XLEN-1:W]};
        end else begin : g_single
            assign result_next = i_alu_rd;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            rs1_reg     <= '0;
            op_b_reg    <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
            sub_reg     <= 1'b0;
            bool_op_reg <= 2'b00;
            cmp_eq_reg  <= 1'b0;
            cmp_sig_reg <= 1'b0;
            rd_sel_reg  <= 3'b000;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
            en_reg      <= 1'b0;
            cnt0_reg    <= 1'b0;
            cmp_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        rs1_reg     <= i_rs1;
                        op_b_reg    <= i_op_b;
                        sub_reg     <= i_sub;
                        bool_op_reg <= i_bool_op;
                        cmp_eq_reg  <= i_cmp_eq;
                        cmp_sig_reg <= i_cmp_sig;
                        rd_sel_reg  <= i_rd_sel;
                        ready_reg   <= 1'b0;
                        state_reg   <= PRIME;
                    end
                end
                PRIME: begin
                    // ALU carry was preloaded with sub during this idle-enable cycle.
                    en_reg    <= 1'b1;
                    cnt0_reg  <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= RUN;
                end
                RUN: begin
                    rs1_reg  <= rs1_reg >> W;
                    op_b_reg <= op_b_reg >> W;
                    cnt0_reg <= 1'b0;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (rd_sel_reg[1] && cnt_reg == LAST) begin
                        result_reg <= {{(XLEN-1){1'b0}}, i_alu_cmp};
                    end else begin
                        result_reg <= result_next;
                    end
                    if (cnt_reg == LAST) begin
                        cmp_reg   <= i_alu_cmp;
                        en_reg    <= 1'b0;
                        valid_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_ready       = ready_reg;
    assign o_valid       = valid_reg;
    assign o_result      = result_reg;
    assign o_cmp         = cmp_reg;
    assign o_alu_en      = en_reg;
    assign o_alu_cnt0    = cnt0_reg;
    assign o_alu_sub     = sub_reg;
    assign o_alu_bool_op = bool_op_reg;
    assign o_alu_cmp_eq  = cmp_eq_reg;
    assign o_alu_cmp_sig = cmp_sig_reg;
    // The ALU slt path stays off; slt results are formed here from the final cmp.
    assign o_alu_rd_sel  = {rd_sel_reg[2], 1'b0, rd_sel_reg[0]};
    assign o_alu_rs1     = rs1_reg[W-1:0];
    assign o_alu_op_b    = op_b_reg[W-1:0];
    assign o_alu_buf     = '0;

endmodule

// File: tb/tb_serv_alu_digit_seq.sv
// Scoreboard bench for serv_alu_digit_seq, with a behavioural digit-serial ALU
// connected behind it so complete operations can be checked end to end.
module tb_serv_alu_digit_seq;
    localparam int W    = 8;
    localparam int XLEN = 32;
    localparam int N    = XLEN / W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic            ready;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            sub = 1'b0;
    logic [1:0]      bool_op = 2'b00;
    logic            cmp_eq = 1'b0;
    logic            cmp_sig = 1'b0;
    logic [2:0]      rd_sel = 3'b000;
    logic            alu_en, alu_cnt0, alu_sub, alu_cmp_eq, alu_cmp_sig;
    logic [1:0]      alu_bool_op;
    logic [2:0]      alu_rd_sel;
    logic [W-1:0]    alu_rs1, alu_op_b, alu_buf, alu_rd;
    logic            alu_cmp;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            cmp;

    serv_alu_digit_seq #(.W(W), .XLEN(XLEN)) dut (
        .clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_rs1(rs1), .i_op_b(op_b), .i_sub(sub), .i_bool_op(bool_op),
        .i_cmp_eq(cmp_eq), .i_cmp_sig(cmp_sig), .i_rd_sel(rd_sel),
        .o_alu_en(alu_en), .o_alu_cnt0(alu_cnt0), .o_alu_sub(alu_sub),
        .o_alu_bool_op(alu_bool_op), .o_alu_cmp_eq(alu_cmp_eq),
        .o_alu_cmp_sig(alu_cmp_sig), .o_alu_rd_sel(alu_rd_sel),
        .o_alu_rs1(alu_rs1), .o_alu_op_b(alu_op_b), .o_alu_buf(alu_buf),
        .i_alu_rd(alu_rd), .i_alu_cmp(alu_cmp),
        .o_valid(res_valid), .i_ready(res_ready), .o_result(result), .o_cmp(cmp)
    );

    always #5 clk = ~clk;

    // Behavioural serial ALU: carry preloads with sub while disabled, eq chains via cmp_q.
    logic         carry_q = 1'b0;
    logic         cmp_q = 1'b0;
    logic [W:0]   sum;
    logic [W-1:0] b_eff, bool_v;
    logic         lt, eq;
    always_comb begin
        b_eff  = alu_op_b ^ {W{alu_sub}};
        sum    = {1'b0, alu_rs1} + {1'b0, b_eff} + {{W{1'b0}}, carry_q};
        bool_v = ((alu_rs1 ^ alu_op_b) & {W{~alu_bool_op[0]}}) |
                 ({W{alu_bool_op[1]}} & alu_op_b & alu_rs1);
        if (alu_cmp_sig && (alu_rs1[W-1] != alu_op_b[W-1])) lt = alu_rs1[W-1];
        else lt = ~sum[W];
        eq      = (sum[W-1:0] == '0) & (alu_cnt0 | cmp_q);
        alu_cmp = alu_cmp_eq ? eq : lt;
        alu_rd  = ({W{alu_rd_sel[0]}} & sum[W-1:0]) | ({W{alu_rd_sel[2]}} & bool_v);
    end
    always @(posedge clk) begin
        carry_q <= alu_en ? sum[W] : alu_sub;
        if (alu_en) cmp_q <= alu_cmp;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] op_b;
        logic            sub;
        logic [1:0]      bool_op;
        logic            cmp_eq;
        logic            cmp_sig;
        logic [2:0]      rd_sel;
        logic [XLEN-1:0] res;
        logic            cmp;
        logic            chk_cmp;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            cmp;
        logic            chk_cmp;
        int              acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   hs_cyc = -100;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input vec_t v, output int acc);
        int k;
        @(negedge clk);
        rs1 = v.rs1; op_b = v.op_b; sub = v.sub; bool_op = v.bool_op;
        cmp_eq = v.cmp_eq; cmp_sig = v.cmp_sig; rd_sel = v.rd_sel;
        valid = 1'b1;
        k = 0;
        while (!ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        acc = cyc;
        if (!ready) begin
            chk("accept_timeout", 32'(ready), 32'd1);
        end else begin
            sb.push_back('{res: v.res, cmp: v.cmp, chk_cmp: v.chk_cmp, acc: cyc});
            $display("issue rs1=%08h op_b=%08h sub=%0b bool=%0b eq=%0b sig=%0b rd_sel=%03b exp=%08h at cycle %0d",
                     v.rs1, v.op_b, v.sub, v.bool_op, v.cmp_eq, v.cmp_sig, v.rd_sel, v.res, cyc);
        end
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: checks every DONE cycle against the head of the scoreboard, pops on handshake.
    logic valid_prev = 1'b0;
    int   run_idx = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (alu_en) begin
                chk("cnt0", 32'(alu_cnt0), 32'(run_idx == 0));
                chk("alu_rd_sel_slt_off", 32'(alu_rd_sel[1]), 32'd0);
                run_idx++;
            end else begin
                run_idx = 0;
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(res_valid), 32'd0);
                end else begin
                    if (!valid_prev) chk("latency", 32'(cyc - sb[0].acc), 32'(N + 2));
                    chk("ready_in_done", 32'(ready), 32'd0);
                    chk("result", result, sb[0].res);
                    if (sb[0].chk_cmp) chk("cmp", 32'(cmp), 32'(sb[0].cmp));
                    if (res_ready) begin
                        $display("result %08h cmp=%0b at cycle %0d", result, cmp, cyc);
                        void'(sb.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end
        end
        valid_prev = res_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];
    vec_t va, vb, vr;
    int   acc_a, acc_b, acc_r, k;

    initial begin
        vecs = '{
            '{32'h5,        32'h7,        1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h0000000C, 1'b0, 1'b0},
            '{32'h3,        32'h5,        1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFE, 1'b0, 1'b0},
            '{32'hFFFFFFFF, 32'h1,        1'b1, 2'b00, 1'b0, 1'b1, 3'b010, 32'h00000001, 1'b1, 1'b1},
            '{32'hFFFFFFFF, 32'h1,        1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 32'h00000000, 1'b0, 1'b1},
            '{32'h12345678, 32'h12345679, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b1},
            '{32'h12345678, 32'h12345678, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 32'h00000000, 1'b1, 1'b1},
            '{32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b100, 32'h0FF00FF0, 1'b0, 1'b0},
            '{32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 2'b11, 1'b0, 1'b0, 3'b100, 32'hF000F000, 1'b0, 1'b0},
            '{32'h80000000, 32'h7FFFFFFF, 1'b1, 2'b00, 1'b0, 1'b1, 3'b010, 32'h00000001, 1'b1, 1'b1},
            '{32'h80000000, 32'h7FFFFFFF, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 32'h00000000, 1'b0, 1'b1},
            '{32'h000000FF, 32'h00000001, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h00000100, 1'b0, 1'b0}
        };

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_cnt0", 32'(alu_cnt0), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cmp", 32'(cmp), 32'd0);
        chk("rst_ctrl", 32'({alu_sub, alu_bool_op, alu_cmp_eq, alu_cmp_sig, alu_rd_sel}), 32'd0);
        chk("alu_buf", 32'(alu_buf), 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i], acc_a);
            drain();
        end

        // Consumer stalls 5 cycles in DONE, then a queued op is accepted right after the handshake.
        res_ready = 1'b0;
        va = '{32'hFFFFFFFF, 32'h1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h00000000, 1'b0, 1'b0};
        vb = '{32'h00000010, 32'h22, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h00000032, 1'b0, 1'b0};
        issue(va, acc_a);
        fork
            issue(vb, acc_b);
            begin
                k = 0;
                while (!res_valid && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                chk("stall_valid_seen", 32'(res_valid), 32'd1);
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        chk("back_to_back_accept", 32'(acc_b), 32'(hs_cyc + 1));
        drain();

        // Reset while RUN is on its third digit aborts the op.
        vr = '{32'h10, 32'h20, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h00000030, 1'b0, 1'b0};
        issue(vr, acc_r);
        k = 0;
        while (cyc != acc_r + 4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("abort_in_run", 32'(alu_en & ~alu_cnt0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_alu_en", 32'(alu_en), 32'd0);
        chk("abort_result", result, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        vr = '{32'h1, 32'h1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h00000002, 1'b0, 1'b0};
        issue(vr, acc_r);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
